// File: rtl/traffic_light_ctrl.sv
// Two-way intersection sequencer with pedestrian walk phase and emergency hold.
// Phase durations come from a single down-counter reloaded on every state entry.
module traffic_light_ctrl #(
  parameter int unsigned GREEN_CYCLES   = 8,
  parameter int unsigned YELLOW_CYCLES  = 3,
  parameter int unsigned ALL_RED_CYCLES = 2,
  parameter int unsigned PED_CYCLES     = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       emergency,
  input  logic       pedestrian_req,
  output logic [2:0] ns_lights,
  output logic [2:0] ew_lights,
  output logic       ped_walk,
  output logic       emergency_active
);

  localparam int unsigned MaxGy  = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam int unsigned MaxRp  = (ALL_RED_CYCLES > PED_CYCLES) ? ALL_RED_CYCLES : PED_CYCLES;
  localparam int unsigned MaxCyc = (MaxGy > MaxRp) ? MaxGy : MaxRp;
  localparam int unsigned TW     = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [TW-1:0] GreenLoad  = TW'(GREEN_CYCLES - 1);
  localparam logic [TW-1:0] YellowLoad = TW'(YELLOW_CYCLES - 1);
  localparam logic [TW-1:0] AllRedLoad = TW'(ALL_RED_CYCLES - 1);
  localparam logic [TW-1:0] PedLoad    = TW'(PED_CYCLES - 1);

  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampGreen  = 3'b001;

  localparam logic DirNs = 1'b0;
  localparam logic DirEw = 1'b1;

  typedef enum logic [2:0] {
    StAllRed,
    StNsGreen,
    StNsYellow,
    StEwGreen,
    StEwYellow,
    StPedWalk,
    StEmergency
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          next_dir_q, next_dir_d;
  logic          ped_pending_q, ped_pending_d;
  logic          tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StAllRed;
      timer_q       <= AllRedLoad;
      next_dir_q    <= DirNs;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      next_dir_q    <= next_dir_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
    timer_d    = timer_q;
    tick       = (timer_q == '0);

    unique case (state_q)
      StAllRed: begin
        if (emergency) begin
          state_d = StEmergency;
        end else if (tick) begin
          if (ped_pending_q)           state_d = StPedWalk;
          else if (next_dir_q == DirNs) state_d = StNsGreen;
          else                          state_d = StEwGreen;
        end
      end
      StNsGreen:  if (emergency || tick) state_d = StNsYellow;
      StEwGreen:  if (emergency || tick) state_d = StEwYellow;
      StNsYellow: begin
        if (tick) begin
          state_d    = StAllRed;
          next_dir_d = DirEw;
        end
      end
      StEwYellow: begin
        if (tick) begin
          state_d    = StAllRed;
          next_dir_d = DirNs;
        end
      end
      StPedWalk: begin
        if (emergency)  state_d = StEmergency;
        else if (tick)  state_d = StAllRed;
      end
      StEmergency: begin
        if (!emergency) begin
          state_d    = StAllRed;
          next_dir_d = DirNs;
        end
      end
      default: state_d = StAllRed;
    endcase

    // Every state change is an entry, so the timer reloads; otherwise it counts down.
    if (state_d != state_q) begin
      case (state_d)
        StNsGreen, StEwGreen:   timer_d = GreenLoad;
        StNsYellow, StEwYellow: timer_d = YellowLoad;
        StPedWalk:              timer_d = PedLoad;
        StAllRed:               timer_d = AllRedLoad;
        default:                timer_d = '0;
      endcase
    end else if (!tick) begin
      timer_d = timer_q - 1'b1;
    end

    // A request arriving on the very edge that starts a walk stays pending.
    ped_pending_d = pedestrian_req |
                    (ped_pending_q & ~((state_d == StPedWalk) && (state_q != StPedWalk)));
  end

  always_comb begin
    ns_lights        = LampRed;
    ew_lights        = LampRed;
    ped_walk         = 1'b0;
    emergency_active = 1'b0;
    unique case (state_q)
      StNsGreen:   ns_lights = LampGreen;
      StNsYellow:  ns_lights = LampYellow;
      StEwGreen:   ew_lights = LampGreen;
      StEwYellow:  ew_lights = LampYellow;
      StPedWalk:   ped_walk = 1'b1;
      StEmergency: emergency_active = 1'b1;
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: walks the phase sequence cycle by cycle and
// compares {ns_lights, ew_lights, ped_walk, emergency_active} against expected phases.
module tb_traffic_light_ctrl;

  logic       clk;
  logic       rst_n;
  logic       emergency;
  logic       pedestrian_req;
  logic [2:0] ns_lights;
  logic [2:0] ew_lights;
  logic       ped_walk;
  logic       emergency_active;

  int checks = 0;
  int errors = 0;

  // {ns, ew, walk, emergency_active}
  localparam logic [7:0] AR = {3'b100, 3'b100, 1'b0, 1'b0};
  localparam logic [7:0] NG = {3'b001, 3'b100, 1'b0, 1'b0};
  localparam logic [7:0] NY = {3'b010, 3'b100, 1'b0, 1'b0};
  localparam logic [7:0] EG = {3'b100, 3'b001, 1'b0, 1'b0};
  localparam logic [7:0] EY = {3'b100, 3'b010, 1'b0, 1'b0};
  localparam logic [7:0] PW = {3'b100, 3'b100, 1'b1, 1'b0};
  localparam logic [7:0] EM = {3'b100, 3'b100, 1'b0, 1'b1};

  traffic_light_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .emergency        (emergency),
    .pedestrian_req   (pedestrian_req),
    .ns_lights        (ns_lights),
    .ew_lights        (ew_lights),
    .ped_walk         (ped_walk),
    .emergency_active (emergency_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {ns_lights, ew_lights, ped_walk, emergency_active};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  // Samples the next n falling edges, each expected to show the given phase.
  task automatic phase(input string tag, input logic [7:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, exp);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic full_cycle(input string tag);
    phase({tag, "_ar1"}, AR, 2);
    phase({tag, "_ng"},  NG, 8);
    phase({tag, "_ny"},  NY, 3);
    phase({tag, "_ar2"}, AR, 2);
    phase({tag, "_eg"},  EG, 8);
    phase({tag, "_ey"},  EY, 3);
  endtask

  initial begin
    rst_n          = 1'b0;
    emergency      = 1'b0;
    pedestrian_req = 1'b0;

    // Reset state before any clock edge, then held across edges.
    #3 check("reset_noclk", AR);
    phase("reset_held", AR, 2);
    release_reset();

    // Two default 26-cycle periods.
    full_cycle("dflt0");
    full_cycle("dflt1");

    // One-cycle walk request in NS_GREEN cycle 3.
    phase("ped_ar", AR, 2);
    phase("ped_ng", NG, 3);
    pedestrian_req = 1'b1;
    @(negedge clk);
    check("ped_ng_pulse", NG);
    pedestrian_req = 1'b0;
    phase("ped_ng_rest", NG, 4);
    phase("ped_ny",  NY, 3);
    phase("ped_ar2", AR, 2);
    phase("ped_pw",  PW, 6);
    phase("ped_ar3", AR, 2);
    phase("ped_eg",  EG, 8);
    phase("ped_ey",  EY, 3);

    // Emergency during NS_GREEN cycle 3, held 10 cycles.
    phase("emg_ar", AR, 2);
    phase("emg_ng", NG, 3);
    emergency = 1'b1;
    phase("emg_ny",   NY, 3);
    phase("emg_ar1",  AR, 1);
    phase("emg_hold", EM, 6);
    emergency = 1'b0;
    phase("emg_ar2", AR, 2);
    phase("emg_ng2", NG, 8);
    phase("emg_ny2", NY, 3);
    phase("emg_ar3", AR, 2);
    phase("emg_eg",  EG, 8);
    phase("emg_ey",  EY, 3);

    // Emergency in PED_WALK cycle 2 with a walk request during the hold.
    pedestrian_req = 1'b1;
    @(negedge clk);
    check("pwe_ar_a", AR);
    pedestrian_req = 1'b0;
    phase("pwe_ar_b", AR, 1);
    phase("pwe_pw", PW, 2);
    emergency = 1'b1;
    phase("pwe_em_a", EM, 2);
    pedestrian_req = 1'b1;
    @(negedge clk);
    check("pwe_em_req", EM);
    pedestrian_req = 1'b0;
    phase("pwe_em_b", EM, 2);
    emergency = 1'b0;
    phase("pwe_ar2", AR, 2);
    phase("pwe_pw2", PW, 6);
    phase("pwe_ar3", AR, 2);
    phase("pwe_ng",  NG, 8);
    phase("pwe_ny",  NY, 3);

    // Walk request and emergency together in ALL_RED cycle 1.
    @(negedge clk);
    check("both_ar", AR);
    pedestrian_req = 1'b1;
    emergency      = 1'b1;
    @(negedge clk);
    check("both_em", EM);
    pedestrian_req = 1'b0;
    phase("both_em_hold", EM, 2);
    emergency = 1'b0;
    phase("both_ar2", AR, 2);
    phase("both_pw",  PW, 6);
    phase("both_ar3", AR, 2);
    phase("both_ng",  NG, 8);
    phase("both_ny",  NY, 3);

    // Asynchronous reset mid EW_GREEN, then full replay.
    phase("mr_ar", AR, 2);
    phase("mr_eg", EG, 3);
    #2 rst_n = 1'b0;
    #1 check("mr_async", AR);
    release_reset();
    full_cycle("replay");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Sequencing controller for a two-way (north-south / east-west) intersection with a pedestrian phase and an emergency override. It drives the light, walk and emergency-status signals carried on `traffic_if`, taking `emergency` and `pedestrian_req` from that interface. All phase timing comes from an internal down-counter. It is the DUT bound to the layered traffic testbench.

## Interface
- `GREEN_CYCLES`, default 8: cycles per green phase (≥1).
- `YELLOW_CYCLES`, default 3: cycles per yellow phase (≥1).
- `ALL_RED_CYCLES`, default 2: cycles per all-red clearance (≥1).
- `PED_CYCLES`, default 6: cycles per pedestrian walk phase (≥1).
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `emergency`  in  1  emergency vehicle request, level-sensitive.
- `pedestrian_req`  in  1  walk request; a single-cycle pulse is sufficient.
- `ns_lights`  out  3  north-south lamps {red,yellow,green}, one-hot: RED=3'b100, YELLOW=3'b010, GREEN=3'b001.
- `ew_lights`  out  3  east-west lamps, same encoding.
- `ped_walk`  out  1  walk indication.
- `emergency_active`  out  1  high while in the emergency hold state.

## Operation
- The state machine has seven states: ALL_RED, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, PED_WALK, EMERGENCY.
- A `next_dir` flag (NS/EW) selects which green follows ALL_RED.
- Outputs are a Moore decode of the state register:
  - NS_GREEN: NS=GREEN, EW=RED.
  - NS_YELLOW: NS=YELLOW, EW=RED.
  - EW_GREEN and EW_YELLOW: the mirror of the NS states.
  - ALL_RED, PED_WALK and EMERGENCY: both directions RED.
  - `ped_walk`=1 only in PED_WALK. `emergency_active`=1 only in EMERGENCY.
- Phase timer:
  - On entry to a state the timer loads N-1, where N is that state's parameter.
  - It decrements every cycle. The state exits in the cycle the timer reads 0, so every timed state lasts exactly N cycles.
  - EMERGENCY is untimed.
- Normal transitions:
  - ALL_RED end: if `ped_pending`, go to PED_WALK. Otherwise go to the `next_dir` green.
  - NS_GREEN → NS_YELLOW → ALL_RED, with `next_dir`:=EW.
  - EW_GREEN → EW_YELLOW → ALL_RED, with `next_dir`:=NS.
  - PED_WALK end → ALL_RED (clearance); `next_dir` unchanged.
- `ped_pending` (sticky):
  - Set by `pedestrian_req`=1 in any cycle, including during EMERGENCY.
  - Cleared on the transition into PED_WALK.
  - If set and clear coincide, set wins; the request is then served in a later walk.
- Emergency (`emergency` sampled each edge) takes priority over pedestrian service:
  - In NS_GREEN or EW_GREEN: go to that direction's yellow next cycle; the timer reloads YELLOW_CYCLES-1.
  - In either yellow: the yellow completes its full duration. At its end the machine enters ALL_RED.
  - In ALL_RED or PED_WALK: go to EMERGENCY next cycle, abandoning the timer.
  - In EMERGENCY: hold while `emergency`=1. When it is 0, go to ALL_RED (full ALL_RED_CYCLES) with `next_dir`:=NS. Pending pedestrian requests are honoured at that ALL_RED's end.

## Timing
- Reset values (`rst_n`=0, asynchronous, no clock needed):
  - state ALL_RED, timer ALL_RED_CYCLES-1, `next_dir`=NS, `ped_pending`=0.
  - `ns_lights`=`ew_lights`=3'b100, `ped_walk`=0, `emergency_active`=0.
- Reset mid-phase: outputs return to the reset values immediately, mid-cycle. After release, normal sequencing restarts from ALL_RED.
- Input-to-output latency is one edge: an input sampled at edge k changes the state, and therefore the outputs, at edge k.
- There is never a cycle with both directions non-RED.
- The timer width is sized for the largest parameter; no wrap occurs because it reloads on every state entry.
- Default full cycle with no requests: 2+8+3+2+8+3 = 26 cycles.

## Test plan
- Reset release, no inputs (defaults): ALL_RED 2 cycles → NS_GREEN 8 → NS_YELLOW 3 → ALL_RED 2 → EW_GREEN 8 → EW_YELLOW 3 → repeat. Period is 26; lamps are always one-hot with at least one direction RED.
- 1-cycle `pedestrian_req` during NS_GREEN: after NS_YELLOW comes ALL_RED 2 → PED_WALK 6 (`ped_walk`=1, both RED) → ALL_RED 2 → EW_GREEN 8.
- `emergency` asserted at NS_GREEN cycle 3 and held 10 cycles:
  - next edge NS_YELLOW for 3 cycles, then ALL_RED for 1 cycle, then EMERGENCY with `emergency_active`=1 until deassert.
  - After deassert: ALL_RED 2 → NS_GREEN.
- `emergency` during PED_WALK cycle 2, with a `pedestrian_req` pulse during EMERGENCY: `ped_walk` drops the next edge. After deassert, ALL_RED 2 → PED_WALK 6 → ALL_RED 2 → NS_GREEN.
- `pedestrian_req` and `emergency` in the same ALL_RED cycle: EMERGENCY is entered and `ped_pending` stays 1. The walk is served after emergency clears.
- `rst_n` dropped mid-EW_GREEN between clock edges: both lamps 3'b100 and flags 0 without a clock edge. After release the machine replays the reset sequence exactly.
